config_shift_master: RTL and testbench

//  Host-side serial writer for the latched config shift register (SIZESRSTAT static + SIZESRDYN dynamic bits).

---
 rtl/config_shift_master.sv | 76 +++++++
 tb/tb_config_shift_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_shift_master.sv
// config_shift_master: frames a parallel config word onto SEL/SCLK/SDI MSB-first and captures SDO readback
module config_shift_master #(
   parameter int SIZESRSTAT = 88,
   parameter int SIZESRDYN  = 16,
   parameter int CLK_DIV    = 4
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            START,
   input  logic [SIZESRSTAT+SIZESRDYN-1:0] DATA_IN,
   output logic                            BUSY,
   output logic                            DONE,
   output logic                            SCLK,
   output logic                            SEL,
   output logic                            SDI,
   input  logic                            SDO,
   output logic [SIZESRSTAT+SIZESRDYN-1:0] RDBK,
   output logic                            MISMATCH
);
   localparam int TOTAL = SIZESRSTAT + SIZESRDYN;
   localparam int BW = $clog2(TOTAL + 1);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, FIN} state_t;
   state_t state, state_nxt;
   logic [DW-1:0] div;
   logic [BW-1:0] bitcnt;
   logic [TOTAL-1:0] shreg, word, prev_word, rdbk;
   logic prev_valid, phase_end;
   assign phase_end = div == DIV_LAST;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = LEAD;
         LEAD:    if (phase_end) state_nxt = HIGH;
         HIGH:    if (phase_end) state_nxt = (bitcnt == BW'(1)) ? TRAIL : LOW;
         LOW:     if (phase_end) state_nxt = HIGH;
         TRAIL:   if (phase_end) state_nxt = FIN;
         default: state_nxt = IDLE;
      endcase
      BUSY = state != IDLE;
      DONE = state == FIN;
      SCLK = state == HIGH;
      SEL  = BUSY && !DONE;
      SDI  = SEL && shreg[TOTAL-1];
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         div        <= '0;
         bitcnt     <= '0;
         RDBK       <= '0;
         MISMATCH   <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         div   <= (state == IDLE || phase_end) ? '0 : div + DW'(1);
         if (state == IDLE && START) begin
            shreg  <= DATA_IN;
            word   <= DATA_IN;
            bitcnt <= BW'(TOTAL);
         end
         if (state == HIGH && phase_end) begin
            rdbk   <= {rdbk[TOTAL-2:0], SDO};
            bitcnt <= bitcnt - BW'(1);
            if (bitcnt != BW'(1)) shreg <= shreg << 1;
         end
         if (state == FIN) begin
            RDBK       <= rdbk;
            MISMATCH   <= prev_valid && (rdbk != prev_word);
            prev_word  <= word;
            prev_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_config_shift_master.sv
// tb_config_shift_master: table-driven frames with a readback scoreboard, protocol monitor and reset corner cases
module tb_config_shift_master;
   localparam int T = 104;
   localparam int DIVS [3] = '{4, 1, 7};
   typedef struct {logic [T-1:0] data; logic [T-1:0] flip; logic mis;} vec_t;
   typedef struct {logic [T-1:0] data; logic [T-1:0] rdbk; logic mis;} sb_t;
   logic CLK = 1'b0, RST = 1'b1;
   logic [2:0] start = '0, poke = '0;
   logic [2:0] busy, done, sclk, sel, sdi, sdo, mism;
   logic [T-1:0] data_in = '0, poke_mask = '0;
   logic [T-1:0] rdbk [3];
   int n_vec = 0, n_err = 0;
   sb_t sb [$];
   always #5 CLK = ~CLK;
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      logic [T-1:0] tgt = '0;
      logic sdo_q = 1'b0;
      config_shift_master #(.CLK_DIV(DIVS[g])) u_dut (
         .CLK(CLK), .RST(RST), .START(start[g]), .DATA_IN(data_in), .BUSY(busy[g]), .DONE(done[g]),
         .SCLK(sclk[g]), .SEL(sel[g]), .SDI(sdi[g]), .SDO(sdo[g]), .RDBK(rdbk[g]), .MISMATCH(mism[g])
      );
      // target register: SDO presents the bit pushed out by the latest rising SCLK
      always @(posedge sclk[g] or posedge poke[g]) begin
         if (poke[g]) tgt <= tgt ^ poke_mask;
         else begin
            sdo_q <= tgt[T-1];
            tgt   <= {tgt[T-2:0], sdi[g]};
         end
      end
      assign sdo[g] = sdo_q;
   end
   task automatic chk(string name, logic [T-1:0] act, logic [T-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask
   function automatic logic [T-1:0] rnd();
      return T'({$urandom(), $urandom(), $urandom(), $urandom()});
   endfunction
   task automatic wait_done(int g, int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge CLK);
         ok = done[g];
      end
      chk($sformatf("done_seen[%0d]", g), ok, 1);
   endtask
   task automatic run_frame(int g, logic [T-1:0] d, logic [T-1:0] er, logic em);
      sb_t e;
      bit ok;
      cyc();
      if (g == 0) begin
         e.data = d; e.rdbk = er; e.mis = em;
         sb.push_back(e);
      end
      data_in = d;
      start[g] = 1'b1;
      cyc();
      start[g] = 1'b0;
      repeat (150) cyc();
      data_in = ~d;
      wait_done(g, DIVS[g] * (2 * T + 1) + 20, ok);
      cyc();
      cyc();
   endtask
   task automatic poke_tgt(logic [T-1:0] m);
      poke_mask = m;
      poke[0] = 1'b1;
      #1;
      poke[0] = 1'b0;
   endtask
   task automatic chk_reset(string tag);
      chk({tag, "_busy"}, busy[0], 0);
      chk({tag, "_done"}, done[0], 0);
      chk({tag, "_sclk"}, sclk[0], 0);
      chk({tag, "_sel"}, sel[0], 0);
      chk({tag, "_sdi"}, sdi[0], 0);
      chk({tag, "_rdbk"}, rdbk[0], 0);
      chk({tag, "_mismatch"}, mism[0], 0);
   endtask
   // protocol and latency monitor, plus scoreboard pop once RDBK has updated
   initial begin
      int lat [3], pre [3], rises [3], trail [3];
      logic sclk_d [3], sdi_d [3], done_d [3], bad [3], track [3];
      sb_t e;
      for (int g = 0; g < 3; g++) begin
         lat[g] = 0; pre[g] = 0; rises[g] = 0; trail[g] = 0;
         sclk_d[g] = 0; sdi_d[g] = 0; done_d[g] = 0; bad[g] = 0; track[g] = 0;
      end
      forever begin
         @(negedge CLK);
         for (int g = 0; g < 3; g++) begin
            lat[g]++;
            if (sel[g]) begin
               if (sclk[g] && sclk_d[g] && sdi[g] !== sdi_d[g]) bad[g] = 1'b1;
               if (sclk[g] && !sclk_d[g]) begin
                  rises[g]++;
                  trail[g] = 0;
               end else if (!sclk[g]) begin
                  if (rises[g] == 0) pre[g]++;
                  else trail[g]++;
               end
            end
            if (track[g] && lat[g] == 1) chk($sformatf("sel_rise[%0d]", g), sel[g], 1);
            if (done[g]) begin
               chk($sformatf("latency[%0d]", g), lat[g], DIVS[g] * (2 * T + 1) + 1);
               chk($sformatf("sclk_rises[%0d]", g), rises[g], T);
               chk($sformatf("sel_lead[%0d]", g), pre[g] >= DIVS[g], 1);
               chk($sformatf("sel_trail[%0d]", g), trail[g] >= DIVS[g], 1);
               chk($sformatf("sdi_stable[%0d]", g), bad[g], 0);
               track[g] = 0;
            end
            if (g == 0 && done_d[0]) begin
               chk("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("rdbk", rdbk[0], e.rdbk);
                  chk("mismatch", mism[0], e.mis);
                  chk("target_word", gen_dut[0].tgt, e.data);
               end
            end
            if (start[g] && !busy[g] && !RST) begin
               lat[g] = 0; pre[g] = 0; rises[g] = 0; trail[g] = 0; bad[g] = 0; track[g] = 1;
            end
            if (RST) track[g] = 0;
            sclk_d[g] = sclk[g];
            sdi_d[g] = sdi[g];
            done_d[g] = done[g];
         end
      end
   end
   initial begin
      vec_t vec [7];
      sb_t e;
      logic [T-1:0] w, prev, snap;
      bit ok, sd;
      int r;
      for (int i = 0; i < T / 8; i++) vec[0].data[i*8 +: 8] = 8'hA5;
      vec[0].flip = '0; vec[0].mis = 1'b0;
      vec[1] = '{rnd(), '0, 1'b0};
      vec[2] = '{rnd(), '0, 1'b0};
      vec[3] = '{rnd(), T'(1) << 37, 1'b1};
      vec[4] = '{'1, '0, 1'b0};
      vec[5] = '{'0, T'(1) << 103, 1'b1};
      vec[6] = '{T'(1), T'(1), 1'b1};
      RST = 1'b1;
      repeat (3) cyc();
      RST = 1'b0;
      @(negedge CLK);
      chk_reset("init");
      prev = '0;
      for (int i = 0; i < 7; i++) begin
         if (vec[i].flip != '0) poke_tgt(vec[i].flip);
         run_frame(0, vec[i].data, prev ^ vec[i].flip, vec[i].mis);
         prev = vec[i].data;
      end
      // START held across a whole frame: one frame, then a restart after one idle cycle
      w = rnd();
      cyc();
      e.data = w; e.rdbk = prev; e.mis = 1'b0;
      sb.push_back(e);
      data_in = w;
      start[0] = 1'b1;
      wait_done(0, 900, ok);
      @(negedge CLK);
      chk("b2b_idle_gap", busy[0], 0);
      @(negedge CLK);
      chk("b2b_restart", sel[0], 1);
      e.data = w; e.rdbk = w; e.mis = 1'b0;
      sb.push_back(e);
      cyc();
      start[0] = 1'b0;
      data_in = rnd();
      wait_done(0, 900, ok);
      cyc();
      cyc();
      // reset held 3 cycles mid-frame
      data_in = rnd();
      start[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      repeat (300) cyc();
      RST = 1'b1;
      cyc();
      @(negedge CLK);
      chk_reset("midrst");
      cyc();
      cyc();
      RST = 1'b0;
      r = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (sclk[0] || sel[0]) r++;
      end
      chk("midrst_quiet", r, 0);
      snap = gen_dut[0].tgt;
      run_frame(0, rnd(), snap, 1'b0);
      // abort at bit 50 after a valid frame; prev_valid must be cleared
      data_in = rnd();
      start[0] = 1'b1;
      cyc();
      start[0] = 1'b0;
      r = 0;
      sd = 1'b0;
      for (int i = 0; i < 1000 && r < 50; i++) begin
         @(negedge CLK);
         if (sclk[0] && !sd) r++;
         sd = sclk[0];
      end
      chk("abort_bit50_reached", r, 50);
      cyc();
      RST = 1'b1;
      cyc();
      @(negedge CLK);
      chk("abort_sel", sel[0], 0);
      chk("abort_busy", busy[0], 0);
      cyc();
      RST = 1'b0;
      r = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (done[0]) r++;
      end
      chk("abort_no_done", r, 0);
      snap = gen_dut[0].tgt;
      run_frame(0, rnd(), snap, 1'b0);
      // other divider settings
      w = rnd();
      run_frame(1, w, '0, 1'b0);
      chk("target_word_div1", gen_dut[1].tgt, w);
      w = rnd();
      run_frame(2, w, '0, 1'b0);
      chk("target_word_div7", gen_dut[2].tgt, w);
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
